// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: oversampled line, 3-sample mid-bit majority vote,
// valid/ready holding register with framing and overrun pulses.
module uart_rx_oversampled #(
    parameter int unsigned CLOCK_RATE    = 25000000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned RX_OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_enable,
    input  logic       uart_rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned TICK_RATE = BAUD_RATE * RX_OVERSAMPLE;
    localparam int unsigned DIV       = (CLOCK_RATE + TICK_RATE / 2) / TICK_RATE;
    localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W     = $clog2(RX_OVERSAMPLE);
    localparam int unsigned MID       = RX_OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [2:0]        bit_q, bit_d;
    logic              s0_q, s0_d, s1_q, s1_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_busy_q, rx_busy_d;
    logic              frame_error_q, frame_error_d;
    logic              overrun_q, overrun_d;
    logic              tick, sample_tick, end_tick, maj, accept;

    assign tick        = (div_q == DIV_W'(DIV - 1));
    assign sample_tick = tick && (idx_q == IDX_W'(MID + 1));
    assign end_tick    = tick && (idx_q == IDX_W'(RX_OVERSAMPLE - 1));
    // Third vote is the live sample taken at index MID+1.
    assign maj = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

    always_comb begin
        state_d       = state_q;
        div_d         = tick ? '0 : div_q + DIV_W'(1);
        idx_d         = idx_q;
        bit_d         = bit_q;
        s0_d          = s0_q;
        s1_d          = s1_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        accept        = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (tick) begin
            idx_d = end_tick ? '0 : idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(MID - 1)) s0_d = sync2_q;
            if (idx_q == IDX_W'(MID))     s1_d = sync2_q;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_enable && !sync2_q) begin
                    state_d = S_START;
                    div_d   = '0;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (sample_tick && maj) begin
                    state_d = S_IDLE;
                end else if (end_tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (sample_tick) shift_d = {maj, shift_q[7:1]};
                if (end_tick) begin
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (sample_tick) begin
                    if (maj) begin
                        state_d = S_IDLE;
                        accept  = 1'b1;
                    end else begin
                        state_d       = S_WAIT_HIGH;
                        frame_error_d = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Disable aborts silently and leaves the holding register alone.
        if (!rx_enable && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            accept        = 1'b0;
            frame_error_d = 1'b0;
        end

        if (accept) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end

        rx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= S_IDLE;
            div_q         <= '0;
            idx_q         <= '0;
            bit_q         <= '0;
            s0_q          <= 1'b0;
            s1_q          <= 1'b0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_busy_q     <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync1_q       <= uart_rx;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            div_q         <= div_d;
            idx_q         <= idx_d;
            bit_q         <= bit_d;
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_busy_q     <= rx_busy_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_busy     = rx_busy_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule
